// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and
// default payload geometry.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned DEFAULT_WIDTH = 96;
  // All-zero payload decodes as a MIPS NOP.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between upstream, the stage and downstream.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_dffe_rst_n.sv
// WIDTH-bit enable flop with asynchronous active-low reset to RST_VAL.
module dffe_rst_n #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: one main entry plus an optional skid entry that
// breaks the combinational out_ready -> in_ready path.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(DEFAULT_BUBBLE),
  parameter bit               SKID   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  stage_state_t     r_state;
  stage_state_t     w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_xfer   = bus.in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = bus.in_data;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_HALF;
            w_main_en   = 1'b1;
          end
        end
        ST_HALF: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_en = 1'b1;
          end else if (w_in_xfer && SKID) begin
            w_state_nxt = ST_FULL;
            w_skid_en   = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (SKID && w_out_xfer) begin
            w_state_nxt = ST_HALF;
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  dffe_rst_n #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  if (SKID) begin : g_skid
    logic r_in_ready;

    // Registered from next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= (w_state_nxt != ST_FULL);
      end
    end

    assign w_in_ready = r_in_ready;

    dffe_rst_n #(
      .WIDTH   (WIDTH),
      .RST_VAL (BUBBLE)
    ) u_skid (
      .clk   (clk),
      .rst_n (rst),
      .i_en  (w_skid_en),
      .i_d   (bus.in_data),
      .o_q   (w_skid_q)
    );
  end else begin : g_noskid
    logic w_unused_skid_en;

    assign w_unused_skid_en = w_skid_en;
    assign w_in_ready       = !w_out_valid | bus.out_ready;
    assign w_skid_q         = BUBBLE;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_main_q : BUBBLE;
  assign bus.occupancy = r_state;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 96: payload width in bits; 96 covers the pc8/pc/instr triple of a front-end stage.
REQ-002 Parameter BUBBLE, default 0: WIDTH-bit value driven on out_data whenever out_valid=0; 0 decodes as MIPS NOP.
REQ-003 Parameter SKID, default 1: 1 = two-entry skid stage with registered in_ready; 0 = single-entry stage with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream payload present.
REQ-007 in_ready  output  1  stage accepts payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  payload present for downstream.
REQ-010 out_ready  input  1  downstream accepts this cycle; deasserted for a pipeline stall.
REQ-011 out_data  output  WIDTH  payload to downstream.
REQ-012 flush  input  1  synchronous kill of all held and incoming payloads, e.g. a taken branch or exception.
REQ-013 occupancy  output  2  number of held entries, 0 to 2.

Function
REQ-014 Handshakes: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-015 State machine states: EMPTY (occupancy 0), HALF (occupancy 1, main entry held), FULL (occupancy 2, main and skid held); FULL is reachable only when SKID=1.
REQ-016 EMPTY + input transfer -> HALF; main entry loads in_data.
REQ-017 HALF + input transfer + output transfer -> HALF; main entry loads in_data, giving zero-bubble throughput.
REQ-018 HALF + output transfer only -> EMPTY.
REQ-019 HALF + input transfer only -> FULL when SKID=1; skid entry loads in_data.
REQ-020 FULL + output transfer -> HALF; main entry loads the skid entry.
REQ-021 FULL with no output transfer -> FULL; both entries hold.
REQ-022 SKID=1: in_ready is a register output equal to (state != FULL); there is no combinational path from out_ready to in_ready.
REQ-023 SKID=0: in_ready = !out_valid | out_ready, computed combinationally.
REQ-024 out_valid = (state != EMPTY); out_data = main entry when out_valid=1, BUBBLE otherwise.
REQ-025 Payloads leave in acceptance order; no payload is dropped or duplicated except by flush.
REQ-026 Latency: a payload accepted in cycle N is presented on out_data in cycle N+1 at the earliest.
REQ-027 Flush has priority over every other event: the next state is EMPTY, and any same-cycle input or output transfer is void for state update.
REQ-028 Flush does not block upstream: in_ready follows REQ-022/023 normally during flush; in_data accepted in a flush cycle is discarded.
REQ-029 A stall (out_ready=0) with no free entry holds all state, with out_data stable, for any number of cycles.
REQ-030 occupancy mirrors the state encoding exactly, with no glitches between clock edges.

Reset
REQ-031 While rst=0: state is EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, main and skid entries = BUBBLE.
REQ-032 With SKID=1, in_ready=1 during reset; reset asserted mid-transfer discards all held payloads immediately, without waiting for a clock edge.
REQ-033 After rst rises, the first accepting edge is the first rising clk edge.

Structure
REQ-034 The state encoding (EMPTY=0, HALF=1, FULL=2) and the default BUBBLE constant live in the shared CPU package.
REQ-035 Entry storage uses one sub-module, dffe_rst_n, instantiated twice (main and skid): a WIDTH-parametrised enable flop with asynchronous active-low reset to a parameter value.
REQ-036 With SKID=0, the skid entry and FULL-state logic are not generated.

Verification
REQ-037 Stream: SKID=1; inputs 0x1,0x2,0x3 on consecutive cycles; out_ready=1 -> outputs 0x1,0x2,0x3 on cycles 1,2,3; occupancy stays 1.
REQ-038 Stall: SKID=1; 0xA and 0xB accepted; out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held 5 cycles; then out_ready=1 -> 0xA, 0xB in order.
REQ-039 Flush: FULL holding 0xA,0xB, flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=0, occupancy=0; 0xC never appears.
REQ-040 Async reset: FULL state, rst pulled low between edges -> out_valid=0 and occupancy=0 before the next edge.
REQ-041 SKID=0: 0x5 held and out_ready=0 -> in_ready=0; raise out_ready in the same cycle -> in_ready=1 combinationally, and 0x6 is accepted with zero bubble.
REQ-042 Random: 10k cycles of random valid/ready/flush, checked against a scoreboard for ordering, no loss, and BUBBLE whenever out_valid=0.
